neural_unit_sequencer: RTL and testbench

//  Initiator side of the NeuralUnit control interface. Accepts a 4-weight job from an upstream

---
 rtl/nn_ctrl_pkg.sv | 23 ++
 rtl/nn_cycle_counter.sv | 39 +++
 rtl/neural_unit_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_neural_unit_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the NeuralUnit control path: sequencer state encoding
// and the default widths/depths that NeuralUnit and WeightRegBank are built with.
package nn_ctrl_pkg;

    localparam int NN_NUM_WEIGHTS = 4;
    localparam int NN_ADDR_W      = 2;
    localparam int NN_WEIGHT_W    = 8;
    localparam int NN_DATA_W      = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_TRIGGER = 3'd3,
        ST_WAIT    = 3'd4,
        ST_HOLD    = 3'd5
    } nn_state_e;

    function automatic int nn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nn_cycle_counter.sv
// Loadable up-counter with enable and a terminal-count flag against a
// run-time terminal value, so one instance can time several intervals.
module nn_cycle_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority over counting.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == term_i);

endmodule

// File: rtl/neural_unit_sequencer.sv
// Initiator for the NeuralUnit control interface: streams a job's weights into
// the weight bank, lets the shifters settle, fires sumTrigger, waits (with a
// timeout) for layerDone and hands layerOut back over a valid/ready handshake.
module neural_unit_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int NUM_WEIGHTS    = NN_NUM_WEIGHTS,
    parameter int ADDR_W         = NN_ADDR_W,
    parameter int WEIGHT_W       = NN_WEIGHT_W,
    parameter int DATA_W         = NN_DATA_W,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                layer_sel_in,
    input  logic                skip_load,
    input  logic                w_valid,
    input  logic [WEIGHT_W-1:0] w_data,
    output logic                w_ready,
    output logic [WEIGHT_W-1:0] weight,
    output logic [ADDR_W-1:0]   address,
    output logic                write,
    output logic                sumTrigger,
    output logic                layer_Sel,
    input  logic [DATA_W-1:0]   layerOut,
    input  logic                layerDone,
    output logic [DATA_W-1:0]   result,
    output logic                result_valid,
    input  logic                result_ready,
    output logic                busy,
    output logic                timeout_err
);

    // One extra bit so the weight counter can reach NUM_WEIGHTS without wrapping.
    localparam int WCNT_W = ADDR_W + 1;
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(NUM_WEIGHTS - 1);

    // The shared interval counter only ever needs to hold limit-1 of the longer interval.
    localparam int CNT_W = $clog2(nn_max(TIMEOUT_CYCLES, SETTLE_CYCLES));
    localparam logic [CNT_W-1:0] TERM_SETTLE  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);

    nn_state_e           state_q;
    nn_state_e           state_d;
    logic [WCNT_W-1:0]   wcnt_q;
    logic [WEIGHT_W-1:0] weight_q;
    logic [ADDR_W-1:0]   address_q;
    logic                write_q;
    logic                sum_trig_q;
    logic                layer_sel_q;
    logic [DATA_W-1:0]   result_q;
    logic                result_valid_q;
    logic                busy_q;
    logic                timeout_err_q;

    logic                accept;
    logic                cnt_load;
    logic                cnt_en;
    logic [CNT_W-1:0]    cnt_term;
    logic                cnt_tc;

    assign w_ready = (state_q == ST_LOAD);
    assign accept  = w_valid & w_ready;

    // Interval timer: held at zero while idle/loading and reloaded at the trigger,
    // so SETTLE and WAIT each start counting from zero.
    always_comb begin
        cnt_load = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_TRIGGER);
        cnt_en   = ((state_q == ST_SETTLE) || (state_q == ST_WAIT)) && !cnt_tc;
        cnt_term = (state_q == ST_WAIT) ? TERM_TIMEOUT : TERM_SETTLE;
    end

    nn_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_interval_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i ('0),
        .en_i       (cnt_en),
        .term_i     (cnt_term),
        .tc_o       (cnt_tc)
    );

    // Next-state decode; layerDone on the last WAIT cycle takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = skip_load ? ST_SETTLE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && (wcnt_q == LAST_IDX)) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_tc) begin
                    state_d = ST_TRIGGER;
                end
            end
            ST_TRIGGER: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (layerDone) begin
                    state_d = ST_HOLD;
                end else if (cnt_tc) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register plus every registered output; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            wcnt_q         <= '0;
            weight_q       <= '0;
            address_q      <= '0;
            write_q        <= 1'b0;
            sum_trig_q     <= 1'b0;
            layer_sel_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != ST_IDLE);
            write_q    <= 1'b0;
            sum_trig_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        layer_sel_q   <= layer_sel_in;
                        timeout_err_q <= 1'b0;
                        wcnt_q        <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        weight_q  <= w_data;
                        address_q <= wcnt_q[ADDR_W-1:0];
                        write_q   <= 1'b1;
                        wcnt_q    <= wcnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_tc) begin
                        sum_trig_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (layerDone) begin
                        result_q       <= layerOut;
                        result_valid_q <= 1'b1;
                    end else if (cnt_tc) begin
                        timeout_err_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign weight       = weight_q;
    assign address      = address_q;
    assign write        = write_q;
    assign sumTrigger   = sum_trig_q;
    assign layer_Sel    = layer_sel_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_neural_unit_sequencer.sv
// Directed bench for neural_unit_sequencer with hand-computed cycle expectations.
module tb_neural_unit_sequencer;

    localparam int WEIGHT_W = 8;
    localparam int ADDR_W   = 2;
    localparam int DATA_W   = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                layer_sel_in;
    logic                skip_load;
    logic                w_valid;
    logic [WEIGHT_W-1:0] w_data;
    logic                w_ready;
    logic [WEIGHT_W-1:0] weight;
    logic [ADDR_W-1:0]   address;
    logic                write;
    logic                sumTrigger;
    logic                layer_Sel;
    logic [DATA_W-1:0]   layerOut;
    logic                layerDone;
    logic [DATA_W-1:0]   result;
    logic                result_valid;
    logic                result_ready;
    logic                busy;
    logic                timeout_err;

    always #5 clk = ~clk;

    neural_unit_sequencer #(
        .NUM_WEIGHTS    (4),
        .ADDR_W         (ADDR_W),
        .WEIGHT_W       (WEIGHT_W),
        .DATA_W         (DATA_W),
        .SETTLE_CYCLES  (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .layer_sel_in (layer_sel_in),
        .skip_load    (skip_load),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .weight       (weight),
        .address      (address),
        .write        (write),
        .sumTrigger   (sumTrigger),
        .layer_Sel    (layer_Sel),
        .layerOut     (layerOut),
        .layerDone    (layerDone),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle.
    int                  wr_cyc[$];
    logic [ADDR_W-1:0]   wr_addr[$];
    logic [WEIGHT_W-1:0] wr_data[$];
    int                  trig_cyc[$];
    int                  wready_seen = 0;
    int                  unstable = 0;
    logic                prev_rv = 1'b0;
    logic [DATA_W-1:0]   prev_res = '0;

    always @(negedge clk) begin
        if (write) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(address);
            wr_data.push_back(weight);
        end
        if (sumTrigger) trig_cyc.push_back(cyc);
        if (w_ready) wready_seen = wready_seen + 1;
        if (result_valid && prev_rv && (result != prev_res)) unstable = unstable + 1;
        prev_rv  = result_valid;
        prev_res = result;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps until sumTrigger is seen (cycle returned in tcyc) or the limit runs out.
    task automatic wait_trig(input int limit, output int tcyc);
        bit found;
        found = 1'b0;
        tcyc  = -1;
        for (int i = 0; i < limit && !found; i++) begin
            @(negedge clk);
            if (sumTrigger) begin
                tcyc  = cyc;
                found = 1'b1;
            end
            tick();
        end
        if (!found) chk("trig_wait_expired", 64'(0), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int tc;
        int wb;
        int tb;
        int rb;
        int ub;
        int acc;
        int k;
        logic [WEIGHT_W-1:0] d2 [4];
        logic [WEIGHT_W-1:0] d3 [4];
        int                  ec3 [4];

        d2  = '{8'h11, 8'h22, 8'h33, 8'h44};
        d3  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        ec3 = '{2, 5, 8, 11};

        // 1: reset held with start asserted
        reset = 1'b0; start = 1'b1; layer_sel_in = 1'b1; skip_load = 1'b0;
        w_valid = 1'b1; w_data = 8'hAA; result_ready = 1'b0;
        layerDone = 1'b0; layerOut = '0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy",     64'(busy),         64'(0));
        chk("rst_w_ready",  64'(w_ready),      64'(0));
        chk("rst_write",    64'(write),        64'(0));
        chk("rst_trig",     64'(sumTrigger),   64'(0));
        chk("rst_layersel", 64'(layer_Sel),    64'(0));
        chk("rst_weight",   64'(weight),       64'(0));
        chk("rst_address",  64'(address),      64'(0));
        chk("rst_result",   64'(result),       64'(0));
        chk("rst_rvalid",   64'(result_valid), 64'(0));
        chk("rst_timeout",  64'(timeout_err),  64'(0));
        start = 1'b0; w_valid = 1'b0; layer_sel_in = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // 2: full job, no bubbles
        wb = wr_cyc.size(); tb = trig_cyc.size();
        t0 = cyc; start = 1'b1; layer_sel_in = 1'b1; skip_load = 1'b0;
        tick(); start = 1'b0; layer_sel_in = 1'b0; w_valid = 1'b1; w_data = d2[0];
        tick(); w_data = d2[1];
        tick(); w_data = d2[2];
        tick(); w_data = d2[3];
        tick(); w_valid = 1'b0;
        while (cyc < t0 + 12) tick();
        layerDone = 1'b1; layerOut = 32'hCAFE_0011;
        tick(); layerDone = 1'b0; layerOut = '0;
        @(negedge clk);
        chk("j2_nwrites", 64'(wr_cyc.size() - wb), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("j2_wr_cycle", 64'(wr_cyc[wb+i] - t0), 64'(2 + i));
            chk("j2_wr_addr",  64'(wr_addr[wb+i]),     64'(i));
            chk("j2_wr_data",  64'(wr_data[wb+i]),     64'(d2[i]));
        end
        chk("j2_ntrig",     64'(trig_cyc.size() - tb), 64'(1));
        chk("j2_trig_cyc",  64'(trig_cyc[tb] - t0),    64'(7));
        chk("j2_layersel",  64'(layer_Sel),            64'(1));
        chk("j2_rvalid",    64'(result_valid),         64'(1));
        chk("j2_result",    64'(result),               64'(32'hCAFE_0011));
        tick(); tick();
        @(negedge clk);
        chk("j2_rvalid_hold", 64'(result_valid), 64'(1));
        result_ready = 1'b1;
        tick(); result_ready = 1'b0;
        @(negedge clk);
        chk("j2_rvalid_drop", 64'(result_valid), 64'(0));
        chk("j2_idle_busy",   64'(busy),         64'(0));
        tick();

        // 3: bubbles on the weight stream and delayed result_ready
        wb = wr_cyc.size(); ub = unstable;
        t0 = cyc; start = 1'b1; layer_sel_in = 1'b0; skip_load = 1'b0;
        tick(); start = 1'b0;
        acc = 0; k = 0;
        while (acc < 4 && k < 40) begin
            w_valid = (k % 3 == 0);
            w_data  = d3[acc];
            @(negedge clk);
            if (w_valid && w_ready) acc++;
            k++;
            tick();
        end
        w_valid = 1'b0;
        chk("j3_accepts", 64'(acc), 64'(4));
        wait_trig(20, tc);
        chk("j3_trig_cyc", 64'(tc - t0), 64'(13));
        tick(); tick();
        layerDone = 1'b1; layerOut = 32'h1234_5678;
        tick(); layerDone = 1'b0; layerOut = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("j3_hold_rvalid", 64'(result_valid), 64'(1));
            chk("j3_hold_result", 64'(result),       64'(32'h1234_5678));
            tick();
        end
        result_ready = 1'b1;
        tick(); result_ready = 1'b0;
        @(negedge clk);
        chk("j3_rvalid_drop", 64'(result_valid), 64'(0));
        chk("j3_nwrites",     64'(wr_cyc.size() - wb), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("j3_wr_cycle", 64'(wr_cyc[wb+i] - t0), 64'(ec3[i]));
            chk("j3_wr_addr",  64'(wr_addr[wb+i]),     64'(i));
            chk("j3_wr_data",  64'(wr_data[wb+i]),     64'(d3[i]));
        end
        chk("j3_unstable", 64'(unstable - ub), 64'(0));
        tick();

        // 4: skip_load reuses the bank
        wb = wr_cyc.size(); rb = wready_seen;
        t0 = cyc; start = 1'b1; skip_load = 1'b1; layer_sel_in = 1'b0;
        w_valid = 1'b1; w_data = 8'h5A;
        tick(); start = 1'b0; skip_load = 1'b0;
        wait_trig(10, tc);
        chk("j4_trig_cyc", 64'(tc - t0), 64'(3));
        layerDone = 1'b1; layerOut = 32'h0BAD_F00D;
        tick(); layerDone = 1'b0; w_valid = 1'b0;
        @(negedge clk);
        chk("j4_rvalid",   64'(result_valid), 64'(1));
        chk("j4_result",   64'(result),       64'(32'h0BAD_F00D));
        chk("j4_layersel", 64'(layer_Sel),    64'(0));
        result_ready = 1'b1;
        tick(); result_ready = 1'b0;
        chk("j4_nwrites", 64'(wr_cyc.size() - wb), 64'(0));
        chk("j4_wready",  64'(wready_seen - rb),   64'(0));

        // 5: timeout, then clear on next start, then layerDone exactly at the limit
        t0 = cyc; start = 1'b1; skip_load = 1'b1;
        tick(); start = 1'b0; skip_load = 1'b0;
        while (cyc < t0 + 11) tick();
        @(negedge clk);
        chk("j5_last_wait_busy", 64'(busy),        64'(1));
        chk("j5_last_wait_err",  64'(timeout_err), 64'(0));
        tick();
        @(negedge clk);
        chk("j5_timeout_err",   64'(timeout_err),  64'(1));
        chk("j5_timeout_idle",  64'(busy),         64'(0));
        chk("j5_timeout_rv",    64'(result_valid), 64'(0));
        chk("j5_result_kept",   64'(result),       64'(32'h0BAD_F00D));
        tick();
        t0 = cyc; start = 1'b1; skip_load = 1'b1;
        tick(); start = 1'b0; skip_load = 1'b0;
        @(negedge clk);
        chk("j5_err_cleared", 64'(timeout_err), 64'(0));
        while (cyc < t0 + 11) tick();
        layerDone = 1'b1; layerOut = 32'h7777_0008;
        tick(); layerDone = 1'b0;
        @(negedge clk);
        chk("j5_limit_rvalid", 64'(result_valid), 64'(1));
        chk("j5_limit_result", 64'(result),       64'(32'h7777_0008));
        chk("j5_limit_noerr",  64'(timeout_err),  64'(0));
        result_ready = 1'b1;
        tick(); result_ready = 1'b0;

        // 6: reset after two weights, then a stray layerDone in IDLE
        t0 = cyc; start = 1'b1; layer_sel_in = 1'b1; skip_load = 1'b0;
        tick(); start = 1'b0; w_valid = 1'b1; w_data = 8'h01;
        tick(); w_data = 8'h02;
        tick(); w_valid = 1'b0; reset = 1'b0;
        tick();
        @(negedge clk);
        chk("j6_busy",     64'(busy),         64'(0));
        chk("j6_write",    64'(write),        64'(0));
        chk("j6_address",  64'(address),      64'(0));
        chk("j6_weight",   64'(weight),       64'(0));
        chk("j6_layersel", 64'(layer_Sel),    64'(0));
        chk("j6_w_ready",  64'(w_ready),      64'(0));
        chk("j6_rvalid",   64'(result_valid), 64'(0));
        chk("j6_result",   64'(result),       64'(0));
        chk("j6_trig",     64'(sumTrigger),   64'(0));
        reset = 1'b1;
        tick();
        layerDone = 1'b1; layerOut = 32'h0000_DEAD;
        tick(); layerDone = 1'b0;
        tick();
        @(negedge clk);
        chk("j6_stray_rvalid", 64'(result_valid), 64'(0));
        chk("j6_stray_result", 64'(result),       64'(0));
        chk("j6_stray_busy",   64'(busy),         64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
